// File: rtl/left_shifter.sv
// Fixed-amount logical left shifter: combinational result plus a registered copy
// with valid tracking. Define LEFT_SHIFTER_LOST_DETECT_EN to build lost-bit detection.
module left_shifter #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 13,
  parameter int SHIFT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in,
  input  logic             in_valid,
  output logic [OUT_W-1:0] out,
  output logic [OUT_W-1:0] out_q,
  output logic             out_valid,
  output logic             lost,
  output logic             lost_sticky
);

  if (SHIFT < 0 || SHIFT >= OUT_W || IN_W < 1) begin : g_bad_params
    $error("left_shifter: need 0 <= SHIFT < OUT_W and IN_W >= 1");
  end

  // Wide enough to hold every shifted bit before truncation to OUT_W.
  localparam int EXT_W = (IN_W + SHIFT > OUT_W) ? (IN_W + SHIFT) : OUT_W;

  logic [EXT_W-1:0] ext;

  assign ext = EXT_W'(in) << SHIFT;
  assign out = ext[OUT_W-1:0];

  // Valid-only stream: a beat transfers on every rising edge where in_valid=1;
  // there is no ready, so every valid input is accepted and never stalled.
  logic [OUT_W-1:0] data_d,  data_q;
  logic             valid_d, valid_q;

  always_comb begin
    data_d  = data_q;
    valid_d = 1'b0;
    if (in_valid) begin
      data_d  = out;
      valid_d = 1'b1;
    end
  end

`ifdef LEFT_SHIFTER_LOST_DETECT_EN
  logic lost_c;
  logic sticky_d, sticky_q;

  // Bits of in landing at or above OUT_W after the shift are truncated away.
  always_comb begin
    lost_c = 1'b0;
    for (int i = 0; i < IN_W; i++) begin
      if (i + SHIFT >= OUT_W) lost_c = lost_c | in[i];
    end
  end

  always_comb begin
    sticky_d = sticky_q | (in_valid & lost_c);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q   <= '0;
      valid_q  <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      data_q   <= data_d;
      valid_q  <= valid_d;
      sticky_q <= sticky_d;
    end
  end

  assign lost        = lost_c;
  assign lost_sticky = sticky_q;
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign lost        = 1'b0;
  assign lost_sticky = 1'b0;
`endif

  assign out_q     = data_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_left_shifter.sv
// Directed and random checks of left_shifter: combinational path without a clock,
// then the registered path against a scoreboard of expected out_q values.
module tb_left_shifter;

  localparam int OUT_W = 13;

  logic              clk = 1'b0;
  logic              clk_en = 1'b0;
  logic              rst_n;
  logic [11:0]       in;
  logic              in_valid;
  logic [OUT_W-1:0]  out;
  logic [OUT_W-1:0]  out_q;
  logic              out_valid;
  logic              lost;
  logic              lost_sticky;

  logic [OUT_W-1:0]  exp_q[$];
  int                passed = 0;
  int                total = 0;
  logic [OUT_W-1:0]  held_m;
  logic              sticky_m;

`ifdef LEFT_SHIFTER_LOST_DETECT_EN
  localparam logic DETECT = 1'b1;
`else
  localparam logic DETECT = 1'b0;
`endif

  left_shifter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in          (in),
    .in_valid    (in_valid),
    .out         (out),
    .out_q       (out_q),
    .out_valid   (out_valid),
    .lost        (lost),
    .lost_sticky (lost_sticky)
  );

  // Clock held low until the combinational-only phase is over.
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [OUT_W-1:0] model_out(input logic [11:0] v);
    int unsigned p;
    p = (32'(v) * 4) % 8192;
    return OUT_W'(p);
  endfunction

  function automatic logic model_lost(input logic [11:0] v);
    return DETECT & (v >= 12'h800);
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Pops the scoreboard for an accepted beat, or checks the hold behaviour.
  task automatic check_reg(input string tag, input logic was_valid);
    logic [OUT_W-1:0] e;
    if (was_valid) begin
      if (exp_q.size() == 0) begin
        check({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        held_m = e;
        check({tag, "_out_q"}, 32'(out_q), 32'(e));
      end
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
    end else begin
      check({tag, "_hold"}, 32'(out_q), 32'(held_m));
      check({tag, "_valid"}, 32'(out_valid), 32'd0);
    end
    check({tag, "_sticky"}, 32'(lost_sticky), 32'(sticky_m));
  endtask

  task automatic drive(input logic [11:0] v, input logic vld);
    in = v;
    in_valid = vld;
    if (vld) begin
      exp_q.push_back(model_out(v));
      sticky_m = sticky_m | model_lost(v);
    end
  endtask

  initial begin
    held_m   = '0;
    sticky_m = 1'b0;

    // Combinational path with no clock and rst_n/in_valid left X.
    in = 12'd12;
    #100;
    check("comb_12", 32'(out), 32'd48);
    in = 12'd1;   #1; check("comb_1", 32'(out), 32'd4);
    in = 12'd0;   #1; check("comb_0", 32'(out), 32'd0);
    check("lost_0", 32'(lost), 32'd0);
    in = 12'hFFF; #1; check("comb_fff", 32'(out), 32'h1FFC);
    check("lost_fff", 32'(lost), 32'(DETECT));
    in = 12'h7FF; #1; check("comb_7ff", 32'(out), 32'h1FFC);
    check("lost_7ff", 32'(lost), 32'd0);
    in = 12'h800; #1; check("comb_800", 32'(out), 32'd0);
    check("lost_800", 32'(lost), 32'(DETECT));

    // Reset for two edges.
    clk_en = 1'b1;
    rst_n = 1'b0; in_valid = 1'b0; in = 12'd0;
    cycle(); cycle();
    check("rst_out_q", 32'(out_q), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_sticky", 32'(lost_sticky), 32'd0);

    rst_n = 1'b1;
    drive(12'd12, 1'b1); cycle(); check_reg("v12", 1'b1);
    drive(12'd0, 1'b0);  cycle(); check_reg("idle", 1'b0);

    drive(12'h800, 1'b1); cycle(); check_reg("v800", 1'b1);
    drive(12'd3, 1'b1);   cycle(); check_reg("v3", 1'b1);

    // Mid-stream reset clears everything.
    rst_n = 1'b0; in_valid = 1'b0;
    cycle();
    sticky_m = 1'b0; held_m = '0;
    check("rst2_out_q", 32'(out_q), 32'd0);
    check("rst2_valid", 32'(out_valid), 32'd0);
    check("rst2_sticky", 32'(lost_sticky), 32'd0);

    // Reset wins over in_valid on the same edge.
    in = 12'd5; in_valid = 1'b1;
    cycle();
    check("rstwin_out_q", 32'(out_q), 32'd0);
    check("rstwin_valid", 32'(out_valid), 32'd0);
    check("rstwin_sticky", 32'(lost_sticky), 32'd0);

    // Random burst.
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [11:0] v;
      logic        vld;
      v   = 12'($urandom_range(0, 4095));
      vld = 1'($urandom_range(0, 3) != 0);
      drive(v, vld);
      #1;
      check("rnd_comb", 32'(out), 32'(model_out(v)));
      check("rnd_lost", 32'(lost), 32'(model_lost(v)));
      cycle();
      check_reg("rnd", vld);
    end

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/left_shifter.md
Name: left_shifter

Overview:
- Fixed-amount logical left shifter for the processor datapath; widens a 12-bit immediate/offset into a 13-bit shifted value, e.g. for word-aligned address offsets.
- Primary result `out` is purely combinational, so it is valid without any clock edge.
- A registered copy with valid tracking and a sticky lost-bit flag is provided for pipelined consumers.

Parameters:
- IN_W, 12, input width in bits.
- OUT_W, 13, output width in bits; must satisfy OUT_W > SHIFT.
- SHIFT, 2, constant left-shift amount in bits, 0..OUT_W-1.

Ports:
- clk  input  1  single system clock; all registers update on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in  input  IN_W  value to shift.
- in_valid  input  1  qualifies `in` for the registered path.
- out  output  OUT_W  combinational result.
- out_q  output  OUT_W  registered result.
- out_valid  output  1  qualifies `out_q`.
- lost  output  1  combinational: a nonzero bit of `in` was discarded by truncation.
- lost_sticky  output  1  registered sticky OR of `lost` over accepted inputs.

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is synchronous and active-low.
- Combinational path:
  - `out` = ({in, SHIFT zero bits}) truncated to the low OUT_W bits.
  - Low SHIFT bits of `out` are always 0.
  - Zero fill only; no sign extension.
  - `out` depends only on `in`. It must be correct with `clk`, `rst_n` and `in_valid` unconnected or X.
  - Default parameters: out[12:2] = in[10:0], out[1:0] = 0, and in[11] is discarded.
- Lost-bit detection:
  - `lost` = OR of every in[i] with i + SHIFT >= OUT_W.
  - It is 0 if no such bit exists, e.g. when IN_W + SHIFT <= OUT_W.
- Registered path, 1-cycle latency:
  - On a rising edge with rst_n=0: out_q=0, out_valid=0, lost_sticky=0.
  - Otherwise, when in_valid=1: out_q <= out and out_valid <= 1.
  - Otherwise, when in_valid=0: out_q holds its value and out_valid <= 0.
  - lost_sticky <= lost_sticky | (in_valid & lost). It is cleared only by reset.
- Reset has priority over in_valid on the same edge.
- Reset asserted mid-stream discards the in-flight value.
- There is no backpressure; every valid input is accepted.
- Elaboration must fail if SHIFT >= OUT_W or IN_W < 1.

Optional Feature:
- Macro: LEFT_SHIFTER_LOST_DETECT_EN.
- When defined: `lost` and `lost_sticky` behave as described in Behaviour.
- When undefined: `lost` and `lost_sticky` are tied to constant 0, and no sticky register is built.
- `out`, `out_q` and `out_valid` are unaffected either way.

Test Plan:
- No clock, inputs other than `in` left unconnected: in=12, wait 100 ns -> out=48.
- in=1 -> out=4; in=0 -> out=0. Both are combinational, checked after 1 ns.
- in=0xFFF -> out=0x1FFC. With the macro defined lost=1; without it lost=0.
- rst_n=0 for 2 edges, then rst_n=1 with in=12, in_valid=1 for one edge -> next cycle out_q=48, out_valid=1. Then in_valid=0 -> out_valid=0 and out_q stays 48.
- Macro defined: send in=0x800 valid -> lost_sticky=1 after the edge. Then send in=3 valid -> lost_sticky stays 1 and out_q=12. Then rst_n=0 for one edge -> lost_sticky=0, out_q=0, out_valid=0.
- in_valid=1 and rst_n=0 on the same edge -> out_valid=0 and out_q=0 (reset wins).
